// File: rtl/cr_kme_word_packer_if.sv
// Word-packer stream bundle: narrow word stream in, packed multi-word beat out.
// master = upstream/downstream environment, slave = the packer itself.
interface cr_kme_word_packer_if #(
    parameter int IN_WIDTH = 64,
    parameter int WORDS    = 4
);
    logic [IN_WIDTH-1:0]         in_data;
    logic                        in_eop;
    logic                        in_valid;
    logic                        in_ack;
    logic [IN_WIDTH*WORDS-1:0]   out_data;
    logic [$clog2(WORDS+1)-1:0]  out_words;
    logic                        out_eop;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        output in_data, in_eop, in_valid, out_ready,
        input  in_ack, out_data, out_words, out_eop, out_valid
    );

    modport slave (
        input  in_data, in_eop, in_valid, out_ready,
        output in_ack, out_data, out_words, out_eop, out_valid
    );
endinterface

// File: rtl/cr_kme_word_packer.sv
// Packs IN_WIDTH words from the kme FIFO into WORDS-wide beats, closing on full, eop or idle timeout.
// Latency: beat presented the cycle after its closing word is accepted; one word/cycle sustained.
// Backpressure: a held beat stalls in_ack until out_ready; handover and new accept share a cycle.
module cr_kme_word_packer #(
    parameter int IN_WIDTH = 64,
    parameter int WORDS    = 4,
    parameter int TIMEOUT  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    cr_kme_word_packer_if.slave io
);
    localparam int OUT_W = IN_WIDTH * WORDS;
    localparam int CW    = $clog2(WORDS);
    localparam int OWW   = $clog2(WORDS + 1);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [OUT_W-1:0]  asm_q;
    logic [OUT_W-1:0]  asm_ins;
    logic [OUT_W-1:0]  out_data_q;
    logic [OWW-1:0]    out_words_q;
    logic              out_eop_q;
    logic              accept;
    logic              closing;
    logic              timeout_fire;

    // rst_n gates the ack so the FIFO is never popped while the packer is held in reset.
    assign accept  = rst_n && io.in_valid && ((state != HOLD) || io.out_ready);
    assign closing = accept && ((cnt == CW'(WORDS - 1)) || io.in_eop);

    always_comb begin
        asm_ins = asm_q;
        for (int k = 0; k < WORDS; k++) begin
            if (cnt == CW'(k)) asm_ins[k*IN_WIDTH +: IN_WIDTH] = io.in_data;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int TW = $clog2(TIMEOUT + 1);
            logic [TW-1:0] timer;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                          timer <= '0;
                else if (accept || (state != FILL))  timer <= '0;
                else                                 timer <= timer + TW'(1);
            end

            assign timeout_fire = (state == FILL) && !accept && (timer == TW'(TIMEOUT - 1));
        end else begin : g_no_timer
            assign timeout_fire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (closing)     state_nxt = HOLD;
                else if (accept) state_nxt = FILL;
            end
            FILL: begin
                if (closing || timeout_fire) state_nxt = HOLD;
            end
            HOLD: begin
                if (io.out_ready) begin
                    if (closing)     state_nxt = HOLD;
                    else if (accept) state_nxt = FILL;
                    else             state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        io.in_ack    = accept;
        io.out_valid = (state == HOLD);
        io.out_data  = out_data_q;
        io.out_words = out_words_q;
        io.out_eop   = out_eop_q;
    end

    // The assembly register is cleared at every close, so unused slots of the next beat read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_words_q <= '0;
            out_eop_q   <= 1'b0;
        end else if (accept) begin
            if (closing) begin
                out_data_q  <= asm_ins;
                out_words_q <= OWW'(cnt) + OWW'(1);
                out_eop_q   <= io.in_eop;
                cnt         <= '0;
                asm_q       <= '0;
            end else begin
                asm_q <= asm_ins;
                cnt   <= cnt + CW'(1);
            end
        end else if (timeout_fire) begin
            out_data_q  <= asm_q;
            out_words_q <= OWW'(cnt);
            out_eop_q   <= 1'b0;
            cnt         <= '0;
            asm_q       <= '0;
        end
    end
endmodule
